clkdiv_multi_chan: RTL and testbench



---
 rtl/clkdiv_multi_chan.sv | 141 ++++++++++++++
 tb/tb_clkdiv_multi_chan.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/clkdiv_multi_chan.sv
// Multi-channel programmable clock divider with power-on reset stretcher and phase-align strobe.
// Optional macro CLKDIV_PHASE_EN adds per-channel phase registers loaded into the counter by sync_start.
module clkdiv_multi_chan #(
    parameter int NCH = 4,
    parameter int DIVW = 8,
    parameter int RST_LEN = 65535,
    localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            cfg_we,
    input  logic [CHW:0]    cfg_addr,
    input  logic [DIVW-1:0] cfg_data,
    input  logic            sync_start,
    output logic [NCH-1:0]  div_out,
    output logic [NCH-1:0]  tick,
    output logic            rst_out
);

    localparam int SW = $clog2(RST_LEN + 1);
    localparam logic [SW-1:0] RST_MAX = RST_LEN[SW-1:0];
    localparam logic [CHW:0] NCH_LIM = NCH[CHW:0];

    logic [SW-1:0]   stretch_cnt;
    logic [DIVW-1:0] shadow_d [NCH];
    logic [DIVW-1:0] active_d [NCH];
    logic [DIVW-1:0] cnt      [NCH];
    logic [DIVW-1:0] cnt_init [NCH];

    logic            cfg_sel;
    logic [CHW-1:0]  cfg_ch;
    logic            cfg_ok;

    assign cfg_sel = cfg_addr[CHW];
    assign cfg_ch  = cfg_addr[CHW-1:0];
    assign cfg_ok  = cfg_we && ({1'b0, cfg_ch} < NCH_LIM);

    // rst_out compares the pre-increment count, so it drops RST_LEN edges after release
    always_ff @(posedge clk) begin
        if (!rstn) begin
            stretch_cnt <= '0;
            rst_out     <= 1'b1;
        end else begin
            if (stretch_cnt != RST_MAX) begin
                stretch_cnt <= stretch_cnt + SW'(1);
            end
            rst_out <= (stretch_cnt != RST_MAX);
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                shadow_d[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ok && !cfg_sel && (cfg_ch == CHW'(i))) begin
                    shadow_d[i] <= cfg_data;
                end
            end
        end
    end

`ifdef CLKDIV_PHASE_EN
    logic [DIVW-1:0] phase [NCH];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < NCH; i++) begin
                phase[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (cfg_ok && cfg_sel && (cfg_ch == CHW'(i))) begin
                    phase[i] <= cfg_data;
                end
            end
        end
    end

    // A phase at or beyond the new half-period would never match, so it falls back to 0
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_init[i] = '0;
            if (phase[i] < shadow_d[i]) begin
                cnt_init[i] = phase[i];
            end
        end
    end
`else
    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            cnt_init[i] = '0;
        end
    end
`endif

    // active_d == 0 is the OFF state; new half-periods are only adopted on a falling toggle
    always_ff @(posedge clk) begin
        if (!rstn) begin
            div_out <= '0;
            tick    <= '0;
            for (int i = 0; i < NCH; i++) begin
                active_d[i] <= '0;
                cnt[i]      <= '0;
            end
        end else begin
            for (int i = 0; i < NCH; i++) begin
                tick[i] <= 1'b0;
                if (rst_out) begin
                    div_out[i]  <= 1'b0;
                    active_d[i] <= '0;
                    cnt[i]      <= '0;
                end else if (sync_start && ((active_d[i] != '0) || (shadow_d[i] != '0))) begin
                    div_out[i]  <= 1'b0;
                    active_d[i] <= shadow_d[i];
                    cnt[i]      <= cnt_init[i];
                end else if (active_d[i] == '0) begin
                    div_out[i] <= 1'b0;
                    if (shadow_d[i] != '0) begin
                        active_d[i] <= shadow_d[i];
                        cnt[i]      <= '0;
                    end
                end else if (cnt[i] == (active_d[i] - DIVW'(1))) begin
                    cnt[i] <= '0;
                    if (div_out[i]) begin
                        div_out[i]  <= 1'b0;
                        active_d[i] <= shadow_d[i];
                    end else begin
                        div_out[i] <= 1'b1;
                        tick[i]    <= 1'b1;
                    end
                end else begin
                    cnt[i] <= cnt[i] + DIVW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_clkdiv_multi_chan.sv
// Scoreboard bench for clkdiv_multi_chan: hand-derived pulse schedules feed a tick queue and a waveform model.
// Expectations for the phase-align step follow the CLKDIV_PHASE_EN macro.
module tb_clkdiv_multi_chan;

    localparam int NCH = 3;
    localparam int DIVW = 8;
    localparam int RST_LEN = 8;
    localparam int CHW = 2;
    localparam int NEVER = 1 << 30;

    typedef struct {
        int ch;
        int rise;
        int len;
    } pulse_t;

    typedef struct {
        int             at;
        logic [NCH-1:0] v;
    } tick_t;

    logic            clk = 1'b0;
    logic            rstn;
    logic            cfg_we;
    logic [CHW:0]    cfg_addr;
    logic [DIVW-1:0] cfg_data;
    logic            sync_start;
    logic [NCH-1:0]  div_out;
    logic [NCH-1:0]  tick;
    logic            rst_out;

    pulse_t waves[$];
    tick_t  ticks_q[$];
    int     ecnt = 0;
    int     rst_fall = NEVER;
    int     total = 0;
    int     bad = 0;

    tick_t          mon_t;
    logic [NCH-1:0] mon_tick;

    clkdiv_multi_chan #(
        .NCH(NCH),
        .DIVW(DIVW),
        .RST_LEN(RST_LEN)
    ) dut (
        .clk(clk),
        .rstn(rstn),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_data(cfg_data),
        .sync_start(sync_start),
        .div_out(div_out),
        .tick(tick),
        .rst_out(rst_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) ecnt = ecnt + 1;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s edge=%0d got=%0h want=%0h", name, ecnt, act, exp);
        end
    endtask

    function automatic void add_tick(input int at, input int ch);
        tick_t t;
        for (int i = 0; i < ticks_q.size(); i++) begin
            if (ticks_q[i].at == at) begin
                t = ticks_q[i];
                t.v[ch] = 1'b1;
                ticks_q[i] = t;
                return;
            end
            if (ticks_q[i].at > at) begin
                t.at = at;
                t.v = '0;
                t.v[ch] = 1'b1;
                ticks_q.insert(i, t);
                return;
            end
        end
        t.at = at;
        t.v = '0;
        t.v[ch] = 1'b1;
        ticks_q.push_back(t);
    endfunction

    function automatic void add_pulse(input int ch, input int rise, input int len);
        pulse_t p;
        p.ch = ch;
        p.rise = rise;
        p.len = len;
        waves.push_back(p);
        add_tick(rise, ch);
    endfunction

    function automatic void add_train(input int ch, input int first, input int d, input int upto);
        for (int r = first; r < upto; r += 2 * d) begin
            add_pulse(ch, r, d);
        end
    endfunction

    function automatic void truncate_waves(input int n);
        pulse_t p;
        for (int i = 0; i < waves.size(); i++) begin
            p = waves[i];
            if (p.rise + p.len > n) begin
                p.len = (n > p.rise) ? n - p.rise : 0;
                waves[i] = p;
            end
        end
    endfunction

    function automatic logic [NCH-1:0] exp_div(input int e);
        logic [NCH-1:0] v;
        v = '0;
        for (int i = 0; i < waves.size(); i++) begin
            if (waves[i].rise <= e && e < waves[i].rise + waves[i].len) begin
                v[waves[i].ch] = 1'b1;
            end
        end
        return v;
    endfunction

    // Monitor: samples after every edge, pops the tick scoreboard and checks the waveform model
    always @(posedge clk) begin
        #2;
        mon_tick = '0;
        while (ticks_q.size() > 0 && ticks_q[0].at < ecnt) begin
            mon_t = ticks_q.pop_front();
            check_output("tick_missed", 32'(ecnt), 32'(mon_t.at));
        end
        if (ticks_q.size() > 0 && ticks_q[0].at == ecnt) begin
            mon_t = ticks_q.pop_front();
            mon_tick = mon_t.v;
        end
        check_output("tick", 32'(tick), 32'(mon_tick));
        check_output("div_out", 32'(div_out), 32'(exp_div(ecnt)));
        check_output("rst_out", 32'(rst_out), 32'(ecnt < rst_fall));
    end

    task automatic wait_before(input int n);
        while (ecnt < n - 1) @(negedge clk);
    endtask

    task automatic cfg_write(input int n, input logic sel, input int ch, input int data);
        wait_before(n);
        cfg_we = 1'b1;
        cfg_addr = {sel, CHW'(ch)};
        cfg_data = DIVW'(data);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic pulse_sync(input int n);
        wait_before(n);
        sync_start = 1'b1;
        @(negedge clk);
        sync_start = 1'b0;
    endtask

    task automatic assert_reset(input int n);
        wait_before(n);
        rstn = 1'b0;
        truncate_waves(n);
        rst_fall = NEVER;
    endtask

    task automatic release_reset(input int n);
        wait_before(n);
        rstn = 1'b1;
        rst_fall = n + RST_LEN;
    endtask

    task automatic apply_stimulus();
        // Basic divide: ch0 D=3, ch1 D=1 written during the stretch, channels start at edge 13
        release_reset(4);
        add_train(0, 16, 3, 40);
        add_train(1, 14, 1, 40);
        cfg_write(5, 1'b0, 0, 3);
        cfg_write(6, 1'b0, 1, 1);
        cfg_write(20, 1'b0, 3, 5);
        cfg_write(21, 1'b1, 3, 2);

        // Mid-run reset, then rate change, coincident write and stop
        assert_reset(40);
        release_reset(42);
        add_pulse(0, 55, 4);
        add_pulse(0, 63, 4);
        add_train(0, 69, 2, 90);
        add_pulse(1, 54, 3);
        add_pulse(1, 60, 3);
        add_pulse(1, 66, 3);
        add_train(1, 70, 1, 90);
        add_pulse(2, 53, 2);
        add_pulse(2, 57, 2);
        cfg_write(43, 1'b0, 0, 4);
        cfg_write(44, 1'b0, 1, 3);
        cfg_write(45, 1'b0, 2, 2);
        cfg_write(58, 1'b0, 2, 0);
        cfg_write(60, 1'b0, 3, 7);
        cfg_write(63, 1'b0, 1, 1);
        cfg_write(64, 1'b0, 0, 2);

        // Phase align: sync during stretch is ignored, sync at 110 overrides ch2's rising toggle
        assert_reset(90);
        release_reset(92);
        add_pulse(0, 105, 4);
        add_pulse(1, 105, 4);
        add_pulse(2, 104, 3);
        add_train(0, 114, 4, 140);
`ifdef CLKDIV_PHASE_EN
        add_train(1, 112, 4, 140);
`else
        add_train(1, 114, 4, 140);
`endif
        add_train(2, 113, 3, 140);
        cfg_write(93, 1'b0, 0, 4);
        cfg_write(94, 1'b0, 1, 4);
        cfg_write(95, 1'b0, 2, 3);
        cfg_write(96, 1'b1, 0, 0);
        cfg_write(97, 1'b1, 1, 2);
        cfg_write(98, 1'b1, 2, 5);
        pulse_sync(99);
        pulse_sync(110);

        assert_reset(140);
        wait_before(146);
    endtask

    initial begin
        rstn = 1'b0;
        cfg_we = 1'b0;
        cfg_addr = '0;
        cfg_data = '0;
        sync_start = 1'b0;
        apply_stimulus();
        check_output("tick_queue_empty", 32'(ticks_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
